// File: rtl/pc_seq_pkg.sv
// Shared types and constants for the program-counter sequencer.
// State encoding, default vectors and the instruction size in bytes.
package pc_seq_pkg;

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_TRAP = 2'd2
    } pc_state_t;

    localparam logic [31:0] RESET_VECTOR_DEF = 32'h0000_0000;
    localparam logic [31:0] EXC_VECTOR_DEF   = 32'h0000_0080;
    localparam int unsigned INSTR_BYTES      = 4;

endpackage

// File: rtl/pc_target_sel.sv
// Redirect target selection: jr > jump > branch priority, branch adder,
// and word-alignment check on whichever target wins.
module pc_target_sel
    import pc_seq_pkg::*;
(
    input  logic        i_jr_en,
    input  logic [31:0] i_jr_addr,
    input  logic        i_jump_en,
    input  logic [31:0] i_jump_addr,
    input  logic        i_branch_en,
    input  logic [31:0] i_branch_base,
    input  logic [31:0] i_branch_offset,
    output logic        o_redirect,
    output logic [31:0] o_target,
    output logic        o_target_misaligned
);

    logic [31:0] w_branch_target;

    // Word offset scaled to bytes; carry out of bit 31 is discarded.
    assign w_branch_target = i_branch_base + (i_branch_offset << 2);

    always_comb begin
        o_redirect = 1'b1;
        o_target   = i_jr_addr;
        if (i_jr_en) begin
            o_target = i_jr_addr;
        end else if (i_jump_en) begin
            o_target = i_jump_addr;
        end else if (i_branch_en) begin
            o_target = w_branch_target;
        end else begin
            o_redirect = 1'b0;
        end
    end

    assign o_target_misaligned = (o_target[1:0] != 2'b00);

endmodule

// File: rtl/pc_sequencer.sv
// Architectural PC holder: presents pc to fetch, advances or redirects it.
//   state   | meaning
//   ST_BOOT | after reset, pc not yet valid, requests ignored
//   ST_RUN  | normal fetch, redirects honoured
//   ST_TRAP | one cycle presenting the exception vector, requests ignored
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = RESET_VECTOR_DEF,
    parameter logic [31:0] EXC_VECTOR   = EXC_VECTOR_DEF
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_fetch_ready,
    output logic        o_pc_valid,
    output logic [31:0] o_pc,
    output logic [31:0] o_pc_plus4,
    output logic [5:0]  o_pc_upper,
    input  logic        i_jump_en,
    input  logic [31:0] i_jump_addr,
    input  logic        i_jr_en,
    input  logic [31:0] i_jr_addr,
    input  logic        i_branch_en,
    input  logic [31:0] i_branch_base,
    input  logic [31:0] i_branch_offset,
    output logic        o_flush,
    output logic        o_misalign,
    output logic [31:0] o_epc
);

    pc_state_t   r_state;
    pc_state_t   w_state_nxt;
    logic [31:0] r_pc;
    logic [31:0] r_epc;
    logic        r_flush;
    logic        r_misalign;
    logic [31:0] w_pc_plus4;
    logic        w_redirect;
    logic [31:0] w_target;
    logic        w_target_misaligned;
    logic        w_pc_valid;
    logic        w_take_redirect;
    logic        w_advance;

    pc_target_sel u_target_sel (
        .i_jr_en             (i_jr_en),
        .i_jr_addr           (i_jr_addr),
        .i_jump_en           (i_jump_en),
        .i_jump_addr         (i_jump_addr),
        .i_branch_en         (i_branch_en),
        .i_branch_base       (i_branch_base),
        .i_branch_offset     (i_branch_offset),
        .o_redirect          (w_redirect),
        .o_target            (w_target),
        .o_target_misaligned (w_target_misaligned)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_BOOT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_BOOT: w_state_nxt = ST_RUN;
            ST_RUN:  w_state_nxt = (w_redirect && w_target_misaligned) ? ST_TRAP : ST_RUN;
            ST_TRAP: w_state_nxt = ST_RUN;
            default: w_state_nxt = ST_BOOT;
        endcase
    end

    always_comb begin
        w_pc_valid      = (r_state == ST_RUN) || (r_state == ST_TRAP);
        w_take_redirect = (r_state == ST_RUN) && w_redirect;
        w_advance       = w_pc_valid && i_fetch_ready;
    end

    assign w_pc_plus4 = r_pc + 32'(INSTR_BYTES);

    // A redirect wins over the sequential advance regardless of fetch_ready.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pc       <= RESET_VECTOR;
            r_epc      <= 32'h0;
            r_flush    <= 1'b0;
            r_misalign <= 1'b0;
        end else begin
            r_flush    <= w_take_redirect;
            r_misalign <= w_take_redirect && w_target_misaligned;
            if (w_take_redirect) begin
                if (w_target_misaligned) begin
                    r_pc  <= EXC_VECTOR;
                    r_epc <= w_target;
                end else begin
                    r_pc <= w_target;
                end
            end else if (w_advance) begin
                r_pc <= w_pc_plus4;
            end
        end
    end

    assign o_pc_valid = w_pc_valid;
    assign o_pc       = r_pc;
    assign o_pc_plus4 = w_pc_plus4;
    assign o_pc_upper = w_pc_plus4[31:26];
    assign o_flush    = r_flush;
    assign o_misalign = r_misalign;
    assign o_epc      = r_epc;

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Program-counter sequencer for the single-issue MIPS datapath. Holds the architectural PC, presents it to instruction fetch under a valid/ready handshake, and selects the next PC from sequential PC+4, conditional branch, register jump (jr) or absolute jump. It sits on both sides of the 26-to-32-bit jump concatenation stage: it drives that stage's 6-bit upper field with `pc_upper` and consumes its 32-bit result on `jump_addr`. Misaligned redirect targets trap to an exception vector.

## Interface
- `RESET_VECTOR`, 32'h0000_0000, PC loaded on reset.
- `EXC_VECTOR`, 32'h0000_0080, PC loaded on misaligned redirect target.
- `clk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `fetch_ready`  in  1  fetch accepts `pc` this cycle.
- `pc_valid`  out  1  `pc` is a valid fetch address.
- `pc`  out  32  current fetch address.
- `pc_plus4`  out  32  `pc + 4`, modulo 2^32.
- `pc_upper`  out  6  `pc_plus4[31:26]`; feeds the concatenator's upper field.
- `jump_en`  in  1  absolute jump request.
- `jump_addr`  in  32  concatenated jump target.
- `jr_en`  in  1  register jump request.
- `jr_addr`  in  32  register jump target.
- `branch_en`  in  1  taken-branch request.
- `branch_base`  in  32  PC+4 of the branch instruction.
- `branch_offset`  in  32  sign-extended word offset.
- `flush`  out  1  one-cycle pulse: younger fetched instructions are squashed.
- `misalign`  out  1  one-cycle pulse: redirect target had `[1:0] != 0`.
- `epc`  out  32  last misaligned target; holds until the next trap.

## Operation
- States: BOOT, RUN, TRAP.
- BOOT: entered on reset. `pc_valid = 0`, all requests ignored. Moves to RUN on the first edge after `rst_n` deasserts.
- RUN: `pc_valid = 1`.
  - Redirect target priority: `jr_en` > `jump_en` > `branch_en`. Lower-priority requests in the same cycle are dropped.
  - Branch target = `branch_base + (branch_offset << 2)`, 32-bit, overflow discarded.
  - Redirect with aligned target: `pc <=` target, `flush` pulses. This is independent of `fetch_ready`; a current unaccepted `pc` is squashed.
  - Redirect with misaligned target: `pc <= EXC_VECTOR`, `epc <=` target, `misalign` and `flush` pulse, state moves to TRAP.
  - No redirect: `pc <= pc_plus4` only when `pc_valid && fetch_ready`; otherwise `pc` holds.
- TRAP: lasts one cycle. `pc_valid = 1` (presenting `EXC_VECTOR`), requests ignored. Next state is RUN, with the sequential advance rule applied this cycle.
- Wrap-around: `pc = 32'hFFFF_FFFC` advances to `32'h0000_0000`; `pc_upper` follows combinationally.

## Timing
- Reset values: `pc = RESET_VECTOR`, `pc_valid = 0`, `flush = 0`, `misalign = 0`, `epc = 0`, state BOOT.
- Reset asserted mid-operation: all of the above apply immediately (asynchronous); pending requests are lost.
- `pc_valid` first rises one cycle after `rst_n` deasserts.
- Redirect latency: request sampled at edge N. New `pc`, `flush` and `misalign` are all visible after edge N, for exactly one cycle for the pulses.
- `pc_plus4` and `pc_upper` are combinational from the `pc` register, with zero latency. Jump-target path: `pc_upper` → concatenator → `jump_addr`, a same-cycle combinational loop-free path.
- Sequential throughput: one address per cycle with `fetch_ready` held high.

## Structure
- Shared package `pc_seq_pkg`:
  - state encoding (BOOT=2'd0, RUN=2'd1, TRAP=2'd2);
  - default `RESET_VECTOR` and `EXC_VECTOR` constants;
  - `INSTR_BYTES = 4`.
- One natural sub-module, `pc_target_sel`: purely combinational priority mux plus branch adder plus alignment check. Outputs `redirect`, `target` and `target_misaligned`.
- The state register, `pc`, `epc` and pulse generation stay in `pc_sequencer`.

## Test plan
- Reset/boot: hold `rst_n = 0` 3 cycles then release, `fetch_ready = 1` → `pc_valid = 0` in the first cycle; then `pc` = 0, 4, 8, 12 on successive cycles.
- Back-pressure: `fetch_ready = 0` for 3 cycles at `pc = 32'h10` → `pc` holds 32'h10, `pc_valid = 1`; it advances to 32'h14 on the first edge with `fetch_ready = 1`.
- Priority: `jr_en`, `jump_en`, `branch_en` together with `jr_addr = 32'h400`, `jump_addr = 32'h800` → `pc = 32'h400` next cycle, `flush` pulses once. Also, `branch_base = 32'h100` with `branch_offset = 32'hFFFF_FFFE` → `pc = 32'hF8`.
- Misalign: `jr_en` with `jr_addr = 32'h402` → `pc = 32'h80`, `epc = 32'h402`, `misalign` and `flush` each high 1 cycle. A `jump_en` asserted during TRAP is ignored.
- Wrap: force `pc = 32'hFFFF_FFFC` via `jr_en` → `pc_upper = 6'h00`, `pc_plus4 = 0`, and `pc = 0` after the handshake.
- Async reset mid-redirect: assert `rst_n = 0` between edges while `jump_en = 1` → `pc = RESET_VECTOR` and `pc_valid = 0` immediately, with no `flush` pulse.
